// File: rtl/vga_fb_arbiter.sv
// Frame-memory arbiter and line-prefetch sequencer: streams one line into a
// two-bank line buffer per request while sharing the memory port with a writer.
module vga_fb_arbiter #(
  parameter int unsigned H_PIXELS = 800,
  parameter int unsigned V_LINES  = 600,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned X_W      = 10,
  parameter int unsigned FAIR_N   = 8
) (
  input  logic              VGA_CLK,
  input  logic              RST_N,
  input  logic              LINE_REQ,
  input  logic [9:0]        LINE_Y,
  input  logic              LINE_BANK,
  output logic              FETCH_BUSY,
  output logic              FETCH_OVERRUN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              LB_WE,
  output logic [X_W:0]      LB_ADDR,
  output logic [DATA_W-1:0] LB_DATA,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ACK
);

  localparam int unsigned CNT_W = $clog2(FAIR_N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic              r_bank;
  logic [X_W-1:0]    r_x;
  logic [X_W-1:0]    r_rd_x;
  logic [X_W-1:0]    r_x1;
  logic              r_v1;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_start;
  logic              w_wr_pend;
  logic              w_fair_wr;
  logic              w_do_rd;
  logic              w_do_wr;
  logic              w_last_x;
  logic [ADDR_W-1:0] w_base;
  logic [CNT_W-1:0]  w_cnt_inc;

  always_comb begin
    w_start   = LINE_REQ && (32'(LINE_Y) < V_LINES);
    // A request is masked while its own ack is showing, so a held request
    // is not written twice.
    w_wr_pend = WR_REQ && !WR_ACK;
    w_fair_wr = (r_cnt == CNT_W'(FAIR_N)) && w_wr_pend;
    w_do_rd   = (r_state == S_FETCH) && !w_fair_wr;
    w_do_wr   = w_wr_pend && ((r_state != S_FETCH) || w_fair_wr);
    w_last_x  = (r_x == X_W'(H_PIXELS - 1));
    w_base    = ADDR_W'(LINE_Y) * ADDR_W'(H_PIXELS);
    w_cnt_inc = (r_cnt == CNT_W'(FAIR_N)) ? r_cnt : r_cnt + CNT_W'(1);
  end

  assign FETCH_BUSY = (r_state != S_IDLE);

  always_ff @(posedge VGA_CLK) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_bank        <= 1'b0;
      r_x           <= '0;
      r_rd_x        <= '0;
      r_x1          <= '0;
      r_v1          <= 1'b0;
      r_cnt         <= '0;
      FETCH_OVERRUN <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_RD        <= 1'b0;
      MEM_WR        <= 1'b0;
      MEM_WDATA     <= '0;
      LB_WE         <= 1'b0;
      LB_ADDR       <= '0;
      LB_DATA       <= '0;
      WR_ACK        <= 1'b0;
    end else begin
      MEM_RD        <= 1'b0;
      MEM_WR        <= 1'b0;
      WR_ACK        <= 1'b0;
      FETCH_OVERRUN <= 1'b0;

      // Read-data pipeline: MEM_RD -> r_v1 (data on MEM_RDATA) -> LB_WE.
      r_v1  <= MEM_RD;
      r_x1  <= r_rd_x;
      LB_WE <= r_v1;
      if (r_v1) begin
        LB_ADDR <= {r_bank, r_x1};
        LB_DATA <= MEM_RDATA;
      end

      if (w_start) begin
        // The capture edge also issues read 0, so the count starts at one.
        FETCH_OVERRUN <= (r_state != S_IDLE);
        r_v1     <= 1'b0;
        LB_WE    <= 1'b0;
        r_base   <= w_base;
        r_bank   <= LINE_BANK;
        r_x      <= X_W'(1);
        r_rd_x   <= '0;
        r_cnt    <= CNT_W'(1);
        MEM_RD   <= 1'b1;
        MEM_ADDR <= w_base;
        r_state  <= (H_PIXELS == 1) ? S_DRAIN : S_FETCH;
      end else begin
        if (w_do_rd) begin
          MEM_RD   <= 1'b1;
          MEM_ADDR <= r_base + ADDR_W'(r_x);
          r_rd_x   <= r_x;
          r_x      <= r_x + X_W'(1);
          r_cnt    <= w_cnt_inc;
          if (w_last_x) begin
            r_state <= S_DRAIN;
          end
        end else if (w_do_wr) begin
          MEM_WR    <= 1'b1;
          WR_ACK    <= 1'b1;
          MEM_ADDR  <= WR_ADDR;
          MEM_WDATA <= WR_DATA;
          r_cnt     <= '0;
        end
        if ((r_state == S_DRAIN) && !MEM_RD && !r_v1) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed line fetches, writer traffic,
// overrun and reset, with expectations queued at stimulus time.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_req;
  logic [9:0]  line_y;
  logic        line_bank;
  logic        fetch_busy;
  logic        fetch_overrun;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic        lb_we;
  logic [10:0] lb_addr;
  logic [11:0] lb_data;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int t_req;
  bit mon_en;
  bit writer_on;
  logic [18:0] wr_next_addr;
  int w_nwr, w_last_lb, w_busy_first, w_busy_last, w_nlb, w_nack;

  typedef struct { logic [18:0] addr; int cyc; } rd_t;
  typedef struct { logic [10:0] addr; logic [11:0] data; int cyc; } lb_t;
  typedef struct { logic [18:0] addr; logic [11:0] data; } wr_t;
  rd_t rd_q[$];
  lb_t lb_q[$];
  wr_t wr_q[$];
  int  ov_q[$];

  vga_fb_arbiter #(
    .H_PIXELS(800), .V_LINES(600), .ADDR_W(19), .DATA_W(12), .X_W(10), .FAIR_N(8)
  ) dut (
    .VGA_CLK(clk), .RST_N(rst_n), .LINE_REQ(line_req), .LINE_Y(line_y),
    .LINE_BANK(line_bank), .FETCH_BUSY(fetch_busy), .FETCH_OVERRUN(fetch_overrun),
    .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .LB_WE(lb_we), .LB_ADDR(lb_addr), .LB_DATA(lb_data),
    .WR_REQ(wr_req), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_ACK(wr_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] mem_f(input logic [18:0] a);
    logic [18:0] t;
    t = a ^ (a >> 7) ^ 19'h005a5;
    return t[11:0];
  endfunction

  // Memory answers one cycle after MEM_RD.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_f(mem_addr);

  function automatic logic [63:0] outs();
    return 64'({fetch_busy, fetch_overrun, mem_rd, mem_wr, lb_we, wr_ack,
                mem_addr, mem_wdata, lb_addr, lb_data});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    rd_t r;
    lb_t l;
    wr_t w;
    int  oc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_rd || mem_wr) chk("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'(0));
        if (mem_rd) begin
          if (rd_q.size() == 0) chk("unexpected_rd", 64'(1), 64'(0));
          else begin
            r = rd_q.pop_front();
            chk("rd_addr", 64'(mem_addr), 64'(r.addr));
            chk("rd_cycle", 64'(cyc), 64'(r.cyc));
          end
        end
        if (lb_we) begin
          if (lb_q.size() == 0) chk("unexpected_lb_we", 64'(1), 64'(0));
          else begin
            l = lb_q.pop_front();
            chk("lb_addr", 64'(lb_addr), 64'(l.addr));
            chk("lb_data", 64'(lb_data), 64'(l.data));
            chk("lb_cycle", 64'(cyc), 64'(l.cyc));
          end
        end
        if (mem_wr) begin
          if (wr_q.size() == 0) chk("unexpected_wr", 64'(1), 64'(0));
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(w.addr));
            chk("wr_data", 64'(mem_wdata), 64'(w.data));
            chk("wr_ack", 64'(wr_ack), 64'(1));
          end
        end
        if (wr_ack && !mem_wr) chk("stray_ack", 64'(1), 64'(0));
        if (fetch_overrun) begin
          if (ov_q.size() == 0) chk("unexpected_overrun", 64'(1), 64'(0));
          else begin
            oc = ov_q.pop_front();
            chk("overrun_cycle", 64'(cyc), 64'(oc));
          end
        end
      end
    end
  endtask

  task automatic issue_line(input int y, input logic bank, input bit fair,
                            input int nrd, input int nlb);
    rd_t r;
    lb_t l;
    int  rc;
    logic [18:0] a;
    t_req = cyc;
    for (int x = 0; x < nrd; x++) begin
      rc = fair ? (x + 1) + x / 8 : x + 1;
      a = 19'(y * 800 + x);
      r.addr = a;
      r.cyc  = t_req + rc;
      rd_q.push_back(r);
      if (x < nlb) begin
        l.addr = {bank, 10'(x)};
        l.data = mem_f(a);
        l.cyc  = t_req + rc + 2;
        lb_q.push_back(l);
      end
    end
    line_req  = 1'b1;
    line_y    = 10'(y);
    line_bank = bank;
    @(posedge clk); #1;
    line_req = 1'b0;
  endtask

  task automatic watch(input int len, input int wr_upto);
    int rel;
    w_nwr = 0; w_last_lb = -1; w_busy_first = -1; w_busy_last = -1; w_nlb = 0; w_nack = 0;
    repeat (len) begin
      @(negedge clk);
      rel = cyc - t_req;
      if (mem_wr && rel <= wr_upto) w_nwr++;
      if (lb_we) begin w_last_lb = rel; w_nlb++; end
      if (wr_ack) w_nack++;
      if (fetch_busy) begin
        if (w_busy_first < 0) w_busy_first = rel;
        w_busy_last = rel;
      end
    end
  endtask

  task automatic do_write();
    wr_t w;
    int  k;
    w.addr = wr_next_addr;
    w.data = 12'(wr_next_addr * 3 + 19'd7);
    wr_q.push_back(w);
    wr_addr = w.addr;
    wr_data = w.data;
    wr_req  = 1'b1;
    wr_next_addr = wr_next_addr + 19'd1;
    k = 0;
    do begin @(negedge clk); k++; end while (!wr_ack && k < 200);
    if (!wr_ack) chk("wr_ack_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic writer_loop();
    while (writer_on) do_write();
    wr_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; line_req = 1'b0; line_y = '0; line_bank = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mon_en = 1'b0; writer_on = 1'b0; wr_next_addr = 19'h10000;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", outs(), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Line 0, bank 0, no writer.
    issue_line(0, 1'b0, 1'b0, 800, 800);
    watch(810, 0);
    chk("y0_last_lb_cycle", 64'(w_last_lb), 64'(802));
    chk("y0_busy_first", 64'(w_busy_first), 64'(1));
    chk("y0_busy_last", 64'(w_busy_last), 64'(802));
    repeat (5) @(posedge clk); #1;

    // Last line into bank 1, with an out-of-range request mid-fetch.
    issue_line(599, 1'b1, 1'b0, 800, 800);
    repeat (49) @(posedge clk); #1;
    line_req = 1'b1; line_y = 10'd700; line_bank = 1'b0;
    @(posedge clk); #1;
    line_req = 1'b0;
    watch(760, 0);
    chk("y599_last_lb_cycle", 64'(w_last_lb), 64'(802));
    chk("y599_busy_last", 64'(w_busy_last), 64'(802));
    repeat (5) @(posedge clk); #1;

    // y == V_LINES is ignored.
    issue_line(600, 1'b0, 1'b0, 0, 0);
    watch(20, 0);
    chk("y600_busy", 64'(w_busy_last), 64'(-1));
    chk("y600_lb_we", 64'(w_nlb), 64'(0));
    repeat (5) @(posedge clk); #1;

    // Continuous writer during a fetch.
    writer_on = 1'b1;
    fork
      writer_loop();
      begin
        issue_line(10, 1'b0, 1'b1, 800, 800);
        watch(910, 899);
        writer_on = 1'b0;
      end
    join
    chk("fair_writes_in_fetch", 64'(w_nwr), 64'(99));
    chk("fair_last_lb_cycle", 64'(w_last_lb), 64'(901));
    chk("fair_busy_last", 64'(w_busy_last), 64'(901));
    repeat (5) @(posedge clk); #1;

    // Idle writer: one ack every other cycle.
    writer_on = 1'b1;
    fork
      writer_loop();
      begin
        watch(10, 0);
        writer_on = 1'b0;
      end
    join
    chk("idle_ack_count", 64'(w_nack), 64'(5));
    repeat (5) @(posedge clk); #1;

    // Overrun: y=4 fetch restarted by y=5 in cycle 100.
    issue_line(4, 1'b0, 1'b0, 100, 98);
    repeat (99) @(posedge clk); #1;
    ov_q.push_back(cyc + 1);
    issue_line(5, 1'b0, 1'b0, 800, 800);
    watch(810, 0);
    chk("ovr_last_lb_cycle", 64'(w_last_lb), 64'(802));
    chk("ovr_busy_last", 64'(w_busy_last), 64'(802));
    repeat (5) @(posedge clk); #1;

    // Reset mid-fetch with a write presented on the reset edge.
    issue_line(2, 1'b1, 1'b0, 800, 800);
    repeat (49) @(posedge clk); #1;
    rst_n = 1'b0;
    wr_req = 1'b1; wr_addr = 19'h12345; wr_data = 12'habc;
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_q.delete(); lb_q.delete(); wr_q.delete(); ov_q.delete();
    @(negedge clk);
    chk("reset_mid_outputs", outs(), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    t_req = cyc;
    watch(20, 20);
    chk("post_reset_lb_we", 64'(w_nlb), 64'(0));
    chk("post_reset_ack", 64'(w_nack), 64'(0));
    chk("post_reset_busy", 64'(w_busy_last), 64'(-1));

    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    chk("lb_q_drained", 64'(lb_q.size()), 64'(0));
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    chk("ov_q_drained", 64'(ov_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-memory arbiter and line-prefetch sequencer for the VGA output path. On each line request from the timing generator it streams one full line of pixels from frame memory into one bank of a two-bank line buffer. It also shares the same memory port with a pixel-writer client using a bounded-starvation slot scheme. It sits between the sync/timing block (`VGA_CLK` domain), the frame memory and the line buffer read by scanout.

## Interface
- `H_PIXELS`, 800, pixels per line (words fetched per request)
- `V_LINES`, 600, lines per frame; `LINE_Y` ≥ `V_LINES` is ignored
- `ADDR_W`, 19, frame-memory address width
- `DATA_W`, 12, pixel word width (RGB444)
- `X_W`, 10, line-buffer x index width, ≥ clog2(`H_PIXELS`)
- `FAIR_N`, 8, maximum consecutive display reads before a pending write must be granted a slot

- `VGA_CLK` in 1: sole clock, all logic on rising edge
- `RST_N` in 1: synchronous, active-low reset
- `LINE_REQ` in 1: one-cycle pulse requesting a fetch of line `LINE_Y` into bank `LINE_BANK`
- `LINE_Y` in 10: line number, sampled with `LINE_REQ`
- `LINE_BANK` in 1: destination bank, sampled with `LINE_REQ`
- `FETCH_BUSY` out 1: a fetch is in progress
- `FETCH_OVERRUN` out 1: one-cycle pulse when a request aborts an unfinished fetch
- `MEM_ADDR` out `ADDR_W`, `MEM_RD` out 1, `MEM_WR` out 1, `MEM_WDATA` out `DATA_W`: memory command, all registered
- `MEM_RDATA` in `DATA_W`: read data, valid in the cycle after `MEM_RD`
- `LB_WE` out 1, `LB_ADDR` out 1+`X_W` ({bank, x}), `LB_DATA` out `DATA_W`: line-buffer write
- `WR_REQ` in 1, `WR_ADDR` in `ADDR_W`, `WR_DATA` in `DATA_W`: writer request, held until acknowledged
- `WR_ACK` out 1: high in exactly the cycle its write is on `MEM_WR`

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE → FETCH on `LINE_REQ` with `LINE_Y` < `V_LINES`.
  - Capture base = `LINE_Y`*`H_PIXELS` (truncated to `ADDR_W`), the bank, x=0 and the fairness count=0.
- FETCH issues reads to base+x, x=0..`H_PIXELS`-1, one per granted cycle, in ascending order.
  - → DRAIN after the last read issues.
  - DRAIN → IDLE once the last `LB_WE` has completed.
- `MEM_RD` and `MEM_WR` are never high in the same cycle.
- Arbitration, decided each edge:
  - In IDLE or DRAIN, a pending unmasked `WR_REQ` always wins.
  - In FETCH, a read wins unless fairness count == `FAIR_N` and a write is pending. In that case the next cycle is a write and the count resets to 0.
  - The count increments per read and saturates at `FAIR_N`.
- Ack mask: `WR_REQ` is ignored in the cycle `WR_ACK` is high, so a held request is not written twice. The writer peak rate is therefore one write per 2 cycles.
- Line-buffer path: `MEM_RDATA` is registered.
  - `LB_WE` is high 2 cycles after the corresponding `MEM_RD`, with `LB_ADDR` = {bank, x}.
- `LINE_REQ` while `FETCH_BUSY`:
  - Pulse `FETCH_OVERRUN`.
  - Discard read data already in flight (the pipeline valid bits are cleared, so no `LB_WE` for it).
  - Restart FETCH with the new parameters.
- `LINE_REQ` with `LINE_Y` ≥ `V_LINES`: no action and no overrun. A fetch in progress continues.
- Reset (any state) behaves like an immediate return to IDLE: pending data is discarded and no `WR_ACK` is issued.
  - All outputs 0 and the state is IDLE the cycle after `RST_N` is sampled low.

## Timing
- Reset values: `FETCH_BUSY`, `FETCH_OVERRUN`, `MEM_RD`, `MEM_WR`, `LB_WE`, `WR_ACK` = 0; `MEM_ADDR`, `MEM_WDATA`, `LB_ADDR`, `LB_DATA` = 0.
- `LINE_REQ` sampled in cycle 0:
  - First `MEM_RD` in cycle 1.
  - First `LB_WE` in cycle 3.
  - `FETCH_BUSY` is high from cycle 1 through the cycle of the last `LB_WE`.
- With no writes, the last read is in cycle `H_PIXELS` and the last `LB_WE` in cycle `H_PIXELS`+2.
- With a continuous writer, read n issues in cycle n + floor((n-1)/`FAIR_N`).
  - Defaults: last read in cycle 899, last `LB_WE` in cycle 901. This fits in a 1056-clock line.
- A write sampled at edge k appears on `MEM_WR`/`WR_ACK` in cycle k+1.

## Test plan
- Reset: hold `RST_N`=0 for 3 cycles mid-stream → all outputs 0 the cycle after first low sample; no `WR_ACK`, no `LB_WE` after release until a new request.
- Fetch `LINE_Y`=0, bank 0, no writer → `MEM_ADDR` 0..799 in cycles 1..800; `LB_WE` in cycles 3..802 with `LB_ADDR` 0..799 and data matching the memory model; `FETCH_BUSY` falls after cycle 802.
- Fetch `LINE_Y`=599, bank 1 → `MEM_ADDR` 479200..479999; `LB_ADDR` bit 10 = 1; `LINE_Y`=600 → no reads.
- `WR_REQ` held throughout a fetch, `FAIR_N`=8 → exactly one `MEM_WR` after every 8 reads (99 writes in FETCH); last `LB_WE` in cycle 901; `MEM_RD`&`MEM_WR` never both 1.
- Idle writer: `WR_REQ` held for 10 cycles with `WR_ADDR` changed after each ack → a `WR_ACK` every other cycle; no address is written twice.
- Overrun: second `LINE_REQ` (y=5) at cycle 100 of a y=4 fetch → `FETCH_OVERRUN` pulse; no `LB_WE` from y=4 data after cycle 101; y=5 reads start at address 4000 in cycle 101.
